seg7_scan_reader: RTL and testbench

SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_pattern_decoder.sv | 30 +++
 rtl/seg7_scan_reader.sv | 134 +++++++++++++
 tb/tb_seg7_scan_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan reader: active-low segment patterns,
// special codes and the frame-assembly state type.
package seg7_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;

  localparam logic [SEG_W-1:0] SEG7_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG7_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG7_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG7_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG7_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG7_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG7_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG7_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG7_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG7_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG7_BLANK = 7'h7F;

  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hE;
  localparam logic [CODE_W-1:0] CODE_ERR   = 4'hF;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational map from an active-low segment pattern to a digit code;
// blank decodes to CODE_BLANK, anything unrecognised to CODE_ERR with err set.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]  pattern,
  output logic [CODE_W-1:0] code_c,
  output logic              err_c
);

  always_comb begin
    code_c = CODE_ERR;
    err_c  = 1'b1;
    case (pattern)
      SEG7_0:     begin code_c = 4'h0;       err_c = 1'b0; end
      SEG7_1:     begin code_c = 4'h1;       err_c = 1'b0; end
      SEG7_2:     begin code_c = 4'h2;       err_c = 1'b0; end
      SEG7_3:     begin code_c = 4'h3;       err_c = 1'b0; end
      SEG7_4:     begin code_c = 4'h4;       err_c = 1'b0; end
      SEG7_5:     begin code_c = 4'h5;       err_c = 1'b0; end
      SEG7_6:     begin code_c = 4'h6;       err_c = 1'b0; end
      SEG7_7:     begin code_c = 4'h7;       err_c = 1'b0; end
      SEG7_8:     begin code_c = 4'h8;       err_c = 1'b0; end
      SEG7_9:     begin code_c = 4'h9;       err_c = 1'b0; end
      SEG7_BLANK: begin code_c = CODE_BLANK; err_c = 1'b0; end
      default:    begin code_c = CODE_ERR;   err_c = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 7-segment display bus and assembles one frame of digit codes.
// Optional SEG7_SCAN_READER_ERR_COUNT_EN adds a saturating err_count output.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEG_W-1:0]         seg_in,
  input  logic [NUM_DIGITS-1:0]    an_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [4*NUM_DIGITS-1:0]  code_out,
  output logic [NUM_DIGITS-1:0]    err_out
`ifdef SEG7_SCAN_READER_ERR_COUNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned LOW_W = IDX_W + 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

  logic [SEG_W-1:0]      seg_s, seg_p;
  logic [NUM_DIGITS-1:0] an_s, an_p;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOW_W-1:0]      low_cnt;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_ok, stable, capture, cap_wr, handshake;
  logic [CODE_W-1:0]     dec_code;
  logic                  dec_err;
  logic [NUM_DIGITS-1:0] seen_q;
  state_e                state_q, state_d;

  // Sample stage plus the previous sample used for the stability comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s <= SEG7_BLANK;
      an_s  <= '1;
      seg_p <= SEG7_BLANK;
      an_p  <= '1;
      cnt_q <= '0;
    end else begin
      seg_s <= seg_in;
      an_s  <= an_in;
      seg_p <= seg_s;
      an_p  <= an_s;
      cnt_q <= cnt_d;
    end
  end

  // Selection decode and stability counter; capture fires once as the count hits STABLE_CYCLES-1.
  always_comb begin
    low_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) begin
        low_cnt = low_cnt + LOW_W'(1);
        sel_idx = IDX_W'(i);
      end
    end
    sel_ok  = (low_cnt == LOW_W'(1));
    stable  = sel_ok && (seg_s == seg_p) && (an_s == an_p);
    if (!stable)
      cnt_d = '0;
    else if (cnt_q >= CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);
    capture = stable && (cnt_q == CNT_PRE);
  end

  seg7_pattern_decoder u_dec (
    .pattern (seg_s),
    .code_c  (dec_code),
    .err_c   (dec_err)
  );

  assign cap_wr    = capture && (state_q == ST_COLLECT);
  assign handshake = (state_q == ST_HOLD) && out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (&seen_q) state_d = ST_HOLD;
      ST_HOLD:    if (out_valid && out_ready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // Frame slots double as the output; they only change while collecting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      code_out  <= '1;
      err_out   <= '0;
      seen_q    <= '0;
    end else begin
      out_valid <= (state_d == ST_HOLD);
      if (handshake) begin
        seen_q <= '0;
      end else if (cap_wr) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_idx == IDX_W'(i)) begin
            seen_q[i]         <= 1'b1;
            code_out[4*i +: 4] <= dec_code;
            err_out[i]        <= dec_err;
          end
        end
      end
    end
  end

`ifdef SEG7_SCAN_READER_ERR_COUNT_EN
  // Lifetime count of unrecognised captures; handshakes leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (cap_wr && dec_err && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader with default parameters (4 digits, 8 stable cycles).
module tb_seg7_scan_reader;

  logic        clk, rst_n, out_ready, out_valid;
  logic [6:0]  seg_in;
  logic [3:0]  an_in, err_out;
  logic [15:0] code_out;
`ifdef SEG7_SCAN_READER_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int hs_count = 0;
  logic [15:0] hs_code;
  logic [3:0]  hs_err;
  logic        valid_seen;

  seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .code_out  (code_out),
    .err_out   (err_out)
`ifdef SEG7_SCAN_READER_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) valid_seen = 1'b1;
    if (rst_n && out_valid && out_ready) begin
      hs_count = hs_count + 1;
      hs_code  = code_out;
      hs_err   = err_out;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; seg_in = 7'h7F; an_in = 4'hF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hs_count = 0; hs_code = 16'h0; hs_err = 4'h0; valid_seen = 1'b0;
  endtask

  // Drive one pattern/select pair across n rising edges; returns 1 time unit after the last.
  task automatic show(input logic [6:0] s, input logic [3:0] a, input int n);
    seg_in = s; an_in = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    show(p0, 4'hE, 10); show(p1, 4'hD, 10); show(p2, 4'hB, 10); show(p3, 4'h7, 10);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++; if (code_out !== 16'hFFFF) begin miscompares++; $display("FAIL reset_code: got %h expected FFFF", code_out); end
    vectors++; if (err_out !== 4'h0) begin miscompares++; $display("FAIL reset_err: got %h expected 0", err_out); end
  endtask

  task automatic test_scan();
    do_reset(); out_ready = 1'b1;
    scan4(7'h79, 7'h24, 7'h30, 7'h19);
    show(7'h7F, 4'hF, 3);
    vectors++; if (hs_count !== 1) begin miscompares++; $display("FAIL scan_frames: got %0d expected 1", hs_count); end
    vectors++; if (hs_code !== 16'h4321) begin miscompares++; $display("FAIL scan_code: got %h expected 4321", hs_code); end
    vectors++; if (hs_err !== 4'h0) begin miscompares++; $display("FAIL scan_err: got %h expected 0", hs_err); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL scan_valid_after: got %b expected 0", out_valid); end
  endtask

  task automatic test_all_digits();
    do_reset(); out_ready = 1'b1;
    scan4(7'h12, 7'h02, 7'h78, 7'h00);
    show(7'h7F, 4'hF, 3);
    vectors++; if (hs_code !== 16'h8765) begin miscompares++; $display("FAIL digits_a: got %h expected 8765", hs_code); end
    scan4(7'h10, 7'h40, 7'h24, 7'h19);
    show(7'h7F, 4'hF, 3);
    vectors++; if (hs_count !== 2) begin miscompares++; $display("FAIL digits_frames: got %0d expected 2", hs_count); end
    vectors++; if (hs_code !== 16'h4209) begin miscompares++; $display("FAIL digits_b: got %h expected 4209", hs_code); end
  endtask

  task automatic test_glitch();
    do_reset(); out_ready = 1'b1;
    show(7'h12, 4'hE, 10);
    show(7'h79, 4'hE, 5);
    show(7'h24, 4'hD, 10); show(7'h30, 4'hB, 10); show(7'h19, 4'h7, 10);
    show(7'h7F, 4'hF, 3);
    vectors++; if (hs_count !== 1) begin miscompares++; $display("FAIL glitch_frames: got %0d expected 1", hs_count); end
    vectors++; if (hs_code !== 16'h4325) begin miscompares++; $display("FAIL glitch_code: got %h expected 4325", hs_code); end
  endtask

  task automatic test_err();
    do_reset(); out_ready = 1'b1;
    scan4(7'h40, 7'h79, 7'h7F, 7'h55);
    show(7'h7F, 4'hF, 3);
    vectors++; if (hs_code !== 16'hFE10) begin miscompares++; $display("FAIL err_code: got %h expected FE10", hs_code); end
    vectors++; if (hs_err !== 4'b1000) begin miscompares++; $display("FAIL err_flags: got %b expected 1000", hs_err); end
`ifdef SEG7_SCAN_READER_ERR_COUNT_EN
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL err_count: got %0d expected 1", err_count); end
`endif
  endtask

  task automatic test_backpressure();
    do_reset(); out_ready = 1'b0;
    scan4(7'h79, 7'h24, 7'h30, 7'h19);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    show(7'h12, 4'hE, 10); show(7'h02, 4'hD, 10);
    vectors++; if (code_out !== 16'h4321) begin miscompares++; $display("FAIL bp_hold_code: got %h expected 4321", code_out); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
    vectors++; if (hs_count !== 0) begin miscompares++; $display("FAIL bp_no_hs: got %0d expected 0", hs_count); end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    vectors++; if (hs_count !== 1) begin miscompares++; $display("FAIL bp_hs: got %0d expected 1", hs_count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop: got %b expected 0", out_valid); end
    show(7'h12, 4'hE, 10); show(7'h02, 4'hD, 10); show(7'h78, 4'hB, 10);
    show(7'h7F, 4'hF, 3);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_partial: got %b expected 0", out_valid); end
    show(7'h00, 4'h7, 10);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_fresh_valid: got %b expected 1", out_valid); end
    vectors++; if (code_out !== 16'h8765) begin miscompares++; $display("FAIL bp_fresh_code: got %h expected 8765", code_out); end
  endtask

  task automatic test_no_select();
    do_reset(); out_ready = 1'b1;
    show(7'h30, 4'b1100, 20);
    show(7'h30, 4'b1111, 20);
    vectors++; if (valid_seen !== 1'b0) begin miscompares++; $display("FAIL nosel_valid: got %b expected 0", valid_seen); end
    vectors++; if (code_out !== 16'hFFFF) begin miscompares++; $display("FAIL nosel_code: got %h expected FFFF", code_out); end
  endtask

  task automatic test_reset_in_hold();
    do_reset(); out_ready = 1'b0;
    scan4(7'h79, 7'h24, 7'h30, 7'h19);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_valid: got %b expected 0", out_valid); end
    vectors++; if (code_out !== 16'hFFFF) begin miscompares++; $display("FAIL rst_hold_code: got %h expected FFFF", code_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    vectors++; if (hs_count !== 0) begin miscompares++; $display("FAIL rst_hold_no_hs: got %0d expected 0", hs_count); end
    out_ready = 1'b1;
    show(7'h12, 4'hE, 10); show(7'h02, 4'hD, 10); show(7'h78, 4'hB, 10);
    show(7'h7F, 4'hF, 3);
    vectors++; if (valid_seen !== 1'b0) begin miscompares++; $display("FAIL rst_partial: got %b expected 0", valid_seen); end
    show(7'h00, 4'h7, 10);
    show(7'h7F, 4'hF, 3);
    vectors++; if (hs_count !== 1) begin miscompares++; $display("FAIL rst_frames: got %0d expected 1", hs_count); end
    vectors++; if (hs_code !== 16'h8765) begin miscompares++; $display("FAIL rst_code: got %h expected 8765", hs_code); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_all_digits();
    test_glitch();
    test_err();
    test_backpressure();
    test_no_select();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
